// File: rtl/load_store_unit_if.sv
// Request/response and memory-control bundle between the hart, the load/store unit and memory.
// mem_ctrl.wwidth encoding: 2'b00 byte, 2'b01 halfword, 2'b10 word.
interface load_store_unit_if #(parameter int XLEN = 32);
   typedef struct packed {
      logic [XLEN-1:0] addr;
      logic            wenable;
      logic [1:0]      wwidth;
      logic [XLEN-1:0] wdata;
   } mem_control_t;

   logic              req_valid;
   logic              req_ready;
   logic              req_is_store;
   logic [2:0]        req_funct3;
   logic [XLEN-1:0]   req_addr;
   logic [XLEN-1:0]   req_wdata;
   logic              resp_valid;
   logic [XLEN-1:0]   resp_rdata;
   logic              resp_fault;
   mem_control_t      mem_ctrl;
   logic [XLEN-1:0]   mem_rdata;

   modport master (
      output req_valid, req_is_store, req_funct3, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_fault, mem_ctrl
   );

   modport slave (
      input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_fault, mem_ctrl
   );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time, fixed-latency memory, formatted load result.
// Optional macro LSU_MISALIGN_CHECK_EN turns misaligned halfword/word accesses into faults.
module load_store_unit #(
   parameter int READ_LATENCY = 1
) (
   input  logic              i_clock,
   input  logic              i_reset,
   load_store_unit_if.slave  bus
);
   localparam logic [1:0] WRITE_BYTE     = 2'b00;
   localparam logic [1:0] WRITE_HALFWORD = 2'b01;
   localparam logic [1:0] WRITE_WORD     = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_WAIT   = 2'b10,
      ST_RESP   = 2'b11
   } state_t;

   state_t      r_state;
   logic        r_is_store;
   logic [2:0]  r_funct3;
   logic [2:0]  r_cnt;
   logic        r_req_ready;
   logic        r_resp_valid;
   logic [31:0] r_resp_rdata;
   logic        r_resp_fault;
   logic [31:0] r_mem_addr;
   logic        r_mem_wen;
   logic [1:0]  r_mem_wwidth;
   logic [31:0] r_mem_wdata;
   logic        w_misaligned;
   logic        w_fault;

   function automatic logic f_is_fault(input logic is_store, input logic [2:0] funct3,
                                       input logic misaligned);
      logic illegal;
      if (is_store) begin
         illegal = (funct3 >= 3'b011);
      end else begin
         illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      return illegal || misaligned;
   endfunction

   function automatic logic [1:0] f_wwidth(input logic [2:0] funct3);
      logic [1:0] w;
      case (funct3[1:0])
         2'b00:   w = WRITE_BYTE;
         2'b01:   w = WRITE_HALFWORD;
         default: w = WRITE_WORD;
      endcase
      return w;
   endfunction

   // Byte at the access address is always in [7:0]; no lane shifting.
   function automatic logic [31:0] f_format(input logic [2:0] funct3, input logic [31:0] b);
      logic [31:0] r;
      case (funct3)
         3'b000:  r = {{24{b[7]}}, b[7:0]};
         3'b100:  r = {24'h000000, b[7:0]};
         3'b001:  r = {{16{b[15]}}, b[15:0]};
         3'b101:  r = {16'h0000, b[15:0]};
         3'b010:  r = b;
         default: r = 32'h0000_0000;
      endcase
      return r;
   endfunction

`ifdef LSU_MISALIGN_CHECK_EN
   assign w_misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                         ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
   assign w_misaligned = 1'b0;
`endif

   assign w_fault = f_is_fault(bus.req_is_store, bus.req_funct3, w_misaligned);

   // Request sequencer: IDLE -> ACCESS -> (WAIT) -> RESP -> IDLE, faults jump to RESP.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state      <= ST_IDLE;
         r_is_store   <= 1'b0;
         r_funct3     <= 3'b000;
         r_cnt        <= 3'b000;
         r_req_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= 32'h0000_0000;
         r_resp_fault <= 1'b0;
         r_mem_addr   <= 32'h0000_0000;
         r_mem_wen    <= 1'b0;
         r_mem_wwidth <= WRITE_WORD;
         r_mem_wdata  <= 32'h0000_0000;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.req_valid && r_req_ready) begin
                  r_is_store  <= bus.req_is_store;
                  r_funct3    <= bus.req_funct3;
                  r_req_ready <= 1'b0;
                  if (w_fault) begin
                     r_state      <= ST_RESP;
                     r_resp_valid <= 1'b1;
                     r_resp_fault <= 1'b1;
                     r_resp_rdata <= 32'h0000_0000;
                  end else begin
                     r_state      <= ST_ACCESS;
                     r_mem_addr   <= bus.req_addr;
                     r_mem_wen    <= bus.req_is_store;
                     r_mem_wwidth <= f_wwidth(bus.req_funct3);
                     r_mem_wdata  <= bus.req_wdata;
                  end
               end
            end
            ST_ACCESS: begin
               r_mem_wen <= 1'b0;
               if (r_is_store) begin
                  r_state      <= ST_RESP;
                  r_resp_valid <= 1'b1;
                  r_resp_fault <= 1'b0;
                  r_resp_rdata <= 32'h0000_0000;
               end else begin
                  r_state <= ST_WAIT;
                  r_cnt   <= 3'(READ_LATENCY - 1);
               end
            end
            ST_WAIT: begin
               if (r_cnt == 3'b000) begin
                  r_state      <= ST_RESP;
                  r_resp_valid <= 1'b1;
                  r_resp_fault <= 1'b0;
                  r_resp_rdata <= f_format(r_funct3, bus.mem_rdata);
               end else begin
                  r_cnt <= r_cnt - 3'b001;
               end
            end
            ST_RESP: begin
               r_state      <= ST_IDLE;
               r_resp_valid <= 1'b0;
               r_resp_fault <= 1'b0;
               r_resp_rdata <= 32'h0000_0000;
               r_req_ready  <= 1'b1;
            end
            default: begin
               r_state      <= ST_IDLE;
               r_resp_valid <= 1'b0;
               r_mem_wen    <= 1'b0;
               r_req_ready  <= 1'b1;
            end
         endcase
      end
   end

   assign bus.req_ready  = r_req_ready;
   assign bus.resp_valid = r_resp_valid;
   assign bus.resp_rdata = r_resp_rdata;
   assign bus.resp_fault = r_resp_fault;
   assign bus.mem_ctrl   = {r_mem_addr, r_mem_wen, r_mem_wwidth, r_mem_wdata};
endmodule
